fp_divider_seq: RTL and testbench

Parametrised sequential IEEE-754-style floating-point divider, successor to the single-precision fpdiv/division pair. It computes result = a / b with a radix-2 restoring mantissa iteration, one quotient bit per clock. It adds a start/ready/valid handshake, full special-value handling and four exception flags. It sits on the FPU datapath between the operand register file and the writeback mux, one operation in flight at a time.

---
 rtl/fp_divider_seq.sv | 182 ++++++++++++++++++
 tb/tb_fp_divider_seq.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/fp_divider_seq.sv
// fp_divider_seq: sequential radix-2 restoring floating-point divider.
// Define FPDIV_ROUND_EN for round-to-nearest-even; default build truncates.
module fp_divider_seq #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [EXP_W+MAN_W:0] a,
    input  logic [EXP_W+MAN_W:0] b,
    output logic                 ready,
    output logic                 valid,
    output logic [EXP_W+MAN_W:0] result,
    output logic [3:0]           flags
);
    localparam int QW = MAN_W + 3;
    localparam int RW = MAN_W + 2;
    localparam int EW = EXP_W + 2;
    localparam int CW = $clog2(QW + 1);
    localparam logic signed [EW-1:0] BIAS = EW'((1 << (EXP_W - 1)) - 1);
    localparam logic signed [EW-1:0] EMAX = EW'((1 << EXP_W) - 1);
    localparam logic signed [EW-1:0] ONE = EW'(1);
    localparam logic [EXP_W+MAN_W-1:0] INF_MAG =
        {{EXP_W{1'b1}}, {MAN_W{1'b0}}};
    localparam logic [EXP_W+MAN_W:0] QNAN =
        {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, CALC, NORM, DONE} state_t;
    state_t state, state_nx;

    logic             sa, sb, sq_in;
    logic [EXP_W-1:0] ea, eb;
    logic [MAN_W-1:0] fa, fb;

    assign {sa, ea, fa} = a;
    assign {sb, eb, fb} = b;
    assign sq_in = sa ^ sb;

    logic a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;

    assign a_zero = (ea == '0);
    assign b_zero = (eb == '0);
    assign a_inf  = (&ea) & (fa == '0);
    assign b_inf  = (&eb) & (fb == '0);
    assign a_nan  = (&ea) & (|fa);
    assign b_nan  = (&eb) & (|fb);

    logic                 sp_hit;
    logic [EXP_W+MAN_W:0] sp_res;
    logic [3:0]           sp_flags;

    // Priority order matters: NaN/invalid first, then inf/x before x/0.
    always_comb begin
        sp_hit   = 1'b1;
        sp_res   = '0;
        sp_flags = '0;
        if (a_nan | b_nan | (a_zero & b_zero) | (a_inf & b_inf)) begin
            sp_res   = QNAN;
            sp_flags = 4'b1000;
        end else if (a_inf) begin
            sp_res = {sq_in, INF_MAG};
        end else if (b_zero) begin
            sp_res   = {sq_in, INF_MAG};
            sp_flags = 4'b0100;
        end else if (a_zero | b_inf) begin
            sp_res = {sq_in, {(EXP_W+MAN_W){1'b0}}};
        end else begin
            sp_hit = 1'b0;
        end
    end

    logic [RW-1:0]          rem;
    logic [QW-1:0]          q;
    logic [MAN_W:0]         mb;
    logic signed [EW-1:0]   e;
    logic                   sq;
    logic [CW-1:0]          cnt;

    logic          ge;
    logic [RW-1:0] diff, rem_nx;

    assign ge     = rem >= {1'b0, mb};
    assign diff   = ge ? rem - {1'b0, mb} : rem;
    assign rem_nx = diff << 1;

    logic [QW-1:0]        qn;
    logic signed [EW-1:0] en, er;
    logic [MAN_W-1:0]     man;
    logic [MAN_W:0]       man_r;
    logic                 guard, sticky, inc;

    assign qn     = q[QW-1] ? q : {q[QW-2:0], 1'b0};
    assign en     = q[QW-1] ? e : e - ONE;
    assign man    = qn[QW-2 -: MAN_W];
    assign guard  = qn[1];
    assign sticky = (|rem) | qn[0];

`ifdef FPDIV_ROUND_EN
    assign inc = guard & (sticky | man[0]);
`else
    logic unused_rnd;
    assign inc        = 1'b0;
    assign unused_rnd = guard ^ sticky;
`endif

    assign man_r = {1'b0, man} + {{MAN_W{1'b0}}, inc};
    assign er    = man_r[MAN_W] ? en + ONE : en;

    logic [EXP_W+MAN_W:0] n_res;
    logic [3:0]           n_flags;

    always_comb begin
        n_res   = {sq, er[EXP_W-1:0], man_r[MAN_W-1:0]};
        n_flags = '0;
        if (er >= EMAX) begin
            n_res   = {sq, INF_MAG};
            n_flags = 4'b0010;
        end else if (er[EW-1] | (er == '0)) begin
            n_res   = {sq, {(EXP_W+MAN_W){1'b0}}};
            n_flags = 4'b0001;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: if (start) state_nx = sp_hit ? DONE : CALC;
            CALC: if (cnt == CW'(QW - 1)) state_nx = NORM;
            NORM: state_nx = DONE;
            DONE: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rem    <= '0;
            q      <= '0;
            mb     <= '0;
            e      <= '0;
            sq     <= 1'b0;
            cnt    <= '0;
            result <= '0;
            flags  <= '0;
        end else begin
            unique case (state)
                IDLE: if (start) begin
                    if (sp_hit) begin
                        result <= sp_res;
                        flags  <= sp_flags;
                    end
                    rem <= {2'b01, fa};
                    mb  <= {1'b1, fb};
                    q   <= '0;
                    cnt <= '0;
                    e   <= EW'(ea) - EW'(eb) + BIAS;
                    sq  <= sq_in;
                end
                CALC: begin
                    rem <= rem_nx;
                    q   <= {q[QW-2:0], ge};
                    cnt <= cnt + CW'(1);
                end
                NORM: begin
                    result <= n_res;
                    flags  <= n_flags;
                end
                default: ;
            endcase
        end
    end

    assign ready = (state == IDLE);
    assign valid = (state == DONE);

endmodule

// File: tb/tb_fp_divider_seq.sv
// tb_fp_divider_seq: directed vectors, handshake and reset-abort checks
// for the single-precision build of fp_divider_seq.
module tb_fp_divider_seq;
    logic        clk;
    logic        reset;
    logic        start;
    logic [31:0] a;
    logic [31:0] b;
    logic        ready;
    logic        valid;
    logic [31:0] result;
    logic [3:0]  flags;

    fp_divider_seq dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .a      (a),
        .b      (b),
        .ready  (ready),
        .valid  (valid),
        .result (result),
        .flags  (flags)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk;
    int n_fail;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // lat = edges from the accepting edge to the edge that raises valid
    task automatic do_op(input logic [31:0] ta, input logic [31:0] tb2,
                         output logic [31:0] r, output logic [3:0] f,
                         output int lat);
        @(negedge clk);
        a = ta;
        b = tb2;
        start = 1'b1;
        lat = -1;
        r = '0;
        f = '0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            start = 1'b0;
            if (valid) begin
                lat = i - 1;
                r = result;
                f = flags;
                break;
            end
        end
    endtask

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic [3:0]  fl;
        int          lat;
    } vec_t;

`ifdef FPDIV_ROUND_EN
    localparam logic [31:0] THIRD = 32'h3EAAAAAB;
`else
    localparam logic [31:0] THIRD = 32'h3EAAAAAA;
`endif

    vec_t        vt[16];
    logic [31:0] r;
    logic [3:0]  f;
    int          lat;
    int          nv;
    int          last;

    initial begin
        vt[0]  = '{32'h40C00000, 32'h40000000, 32'h40400000, 4'h0, 27};
        vt[1]  = '{32'h3F800000, 32'h40400000, THIRD,        4'h0, 27};
        vt[2]  = '{32'hBF800000, 32'h00000000, 32'hFF800000, 4'h4, 0};
        vt[3]  = '{32'h00000000, 32'h00000000, 32'h7FC00000, 4'h8, 0};
        vt[4]  = '{32'h7F000000, 32'h3E800000, 32'h7F800000, 4'h2, 27};
        vt[5]  = '{32'h00800000, 32'h40000000, 32'h00000000, 4'h1, 27};
        vt[6]  = '{32'hC0C00000, 32'h40000000, 32'hC0400000, 4'h0, 27};
        vt[7]  = '{32'h7F800000, 32'hC0000000, 32'hFF800000, 4'h0, 0};
        vt[8]  = '{32'h40000000, 32'hFF800000, 32'h80000000, 4'h0, 0};
        vt[9]  = '{32'h7F800001, 32'h3F800000, 32'h7FC00000, 4'h8, 0};
        vt[10] = '{32'hFF800000, 32'h7F800000, 32'h7FC00000, 4'h8, 0};
        vt[11] = '{32'h80000000, 32'h40000000, 32'h80000000, 4'h0, 0};
        vt[12] = '{32'h00400000, 32'h3F800000, 32'h00000000, 4'h0, 0};
        vt[13] = '{32'h7F7FFFFF, 32'h3F000000, 32'h7F800000, 4'h2, 27};
        vt[14] = '{32'h7F000000, 32'h3F800000, 32'h7F000000, 4'h0, 27};
        vt[15] = '{32'h00800000, 32'h3F800000, 32'h00800000, 4'h0, 27};

        n_chk = 0;
        n_fail = 0;
        start = 1'b0;
        a = '0;
        b = '0;
        reset = 1'b1;
        #2 reset = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst ready", 32'(ready), 32'd1);
        chk("rst valid", 32'(valid), 32'd0);
        chk("rst result", result, 32'h0);
        chk("rst flags", 32'(flags), 32'h0);
        reset = 1'b1;

        for (int i = 0; i < 16; i++) begin
            do_op(vt[i].a, vt[i].b, r, f, lat);
            chk($sformatf("v%0d result", i), r, vt[i].res);
            chk($sformatf("v%0d flags", i), 32'(f), 32'(vt[i].fl));
            chk($sformatf("v%0d latency", i), 32'(lat), 32'(vt[i].lat));
            @(negedge clk);
            chk($sformatf("v%0d pulse", i), 32'({valid, ready}), 32'd1);
        end

        // start held high; operands scrambled whenever the block is busy
        @(negedge clk);
        a = 32'h40C00000;
        b = 32'h40000000;
        start = 1'b1;
        nv = 0;
        last = -1;
        for (int c = 1; c <= 95; c++) begin
            @(negedge clk);
            if (valid) begin
                chk("hs result", result, 32'h40400000);
                chk("hs flags", 32'(flags), 32'h0);
                if (last >= 0) chk("hs period", 32'(c - last), 32'd29);
                last = c;
                nv++;
            end
            if (ready) begin
                a = 32'h40C00000;
                b = 32'h40000000;
            end else begin
                a = $urandom;
                b = $urandom;
            end
        end
        start = 1'b0;
        chk("hs count", 32'(nv), 32'd3);
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (ready && !valid) break;
        end
        chk("hs drain", 32'({valid, ready}), 32'd1);

        // reset in the middle of CALC
        @(negedge clk);
        a = 32'h3F800000;
        b = 32'h40400000;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        chk("calc busy", 32'(ready), 32'd0);
        chk("calc held", result, 32'h40400000);
        reset = 1'b0;
        #1;
        chk("abort ready", 32'(ready), 32'd1);
        chk("abort valid", 32'(valid), 32'd0);
        chk("abort result", result, 32'h0);
        chk("abort flags", 32'(flags), 32'h0);
        @(negedge clk);
        reset = 1'b1;
        do_op(32'h40C00000, 32'h40000000, r, f, lat);
        chk("post result", r, 32'h40400000);
        chk("post flags", 32'(f), 32'h0);
        chk("post latency", 32'(lat), 32'd27);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
